// File: rtl/slice_lane_collector_if.sv
// Slice input stream (parity stage -> collector) and lane output stream (collector -> permutation).
// The slave modport is the collector's view; master is the surrounding environment.
interface slice_lane_collector_if #(
    parameter int SLICE_W = 25,
    parameter int DEPTH   = 64,
    parameter int IDX_W   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [SLICE_W-1:0] in_slice;
    logic               out_valid;
    logic               out_ready;
    logic [DEPTH-1:0]   out_lane;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;

    modport master (
        output in_valid, in_slice, out_ready,
        input  in_ready, out_valid, out_lane, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_slice, out_ready,
        output in_ready, out_valid, out_lane, out_idx, out_last
    );
endinterface

// File: rtl/slice_lane_collector.sv
// Transposes 64 x 25-bit slices into 25 x 64-bit lanes and streams them out; lane 0 is valid the
// cycle after the last slice write, out_lane/out_idx hold steady while out_ready is low.
module slice_lane_collector #(
    parameter int SLICE_W = 25,
    parameter int DEPTH   = 64,
    parameter int IDX_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  stray_err,
    slice_lane_collector_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   slice_cnt;
    logic [IDX_W-1:0]   lane_cnt;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [DEPTH-1:0]   store [SLICE_W];

    logic               wr;
    logic               xfer;
    logic               last_slice;
    logic               last_lane;
    logic [ADDR_W-1:0]  waddr;

    assign wr         = bus.in_valid & in_ready_q;
    assign xfer       = out_valid_q & bus.out_ready;
    assign last_slice = (slice_cnt == CNT_W'(DEPTH - 1));
    assign last_lane  = (lane_cnt == IDX_W'(SLICE_W - 1));
    assign waddr      = slice_cnt[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slice_cnt   <= '0;
            lane_cnt    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            stray_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COLLECT;
                        slice_cnt  <= '0;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (wr) begin
                        slice_cnt <= slice_cnt + 1'b1;
                        if (last_slice) begin
                            state       <= DRAIN;
                            lane_cnt    <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (last_lane) begin
                            state       <= DONE;
                            out_valid_q <= 1'b0;
                            frame_done  <= 1'b1;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A slice arriving alongside start is still a stray: the set wins over the clear.
            if (state == IDLE && start) begin
                stray_err <= bus.in_valid;
            end else if (bus.in_valid && !in_ready_q) begin
                stray_err <= 1'b1;
            end
        end
    end

    // Storage carries no reset; stale contents are never visible outside DRAIN.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int k = 0; k < SLICE_W; k++) begin
                store[k][waddr] <= bus.in_slice[k];
            end
        end
    end

    always_comb begin
        bus.out_lane = '0;
        bus.out_idx  = '0;
        if (out_valid_q) begin
            bus.out_lane = store[lane_cnt];
            bus.out_idx  = lane_cnt;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_valid_q & last_lane;

endmodule
